// File: rtl/ddr_preload_engine.sv
// ddr_preload_engine
//    After DDR calibration, copies a table of NUM_WORDS 32-bit words into
//    external memory over Avalon-MM, one DATA_W beat at a time, optionally
//    reads every beat back and compares it with the table contents.
// Ports:
//    avalon_clk, reset      : sole clock, synchronous active-high reset
//    start, cal_success     : preload request pulse, calibration done
//    tbl_addr / tbl_data    : table word lookup (tbl_data combinational)
//    amm_*                  : Avalon-MM master (single-beat bursts)
//    busy, setup_done,
//    setup_fail, err_count  : status; err_count saturates at 16'hFFFF
module ddr_preload_engine #(
   parameter int unsigned DATA_W     = 256,
   parameter int unsigned ADDR_W     = 25,
   parameter int unsigned NUM_WORDS  = 28,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned VERIFY     = 0,
   parameter int unsigned RD_TIMEOUT = 255
) (
   input  logic                  avalon_clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  cal_success,
   output logic [9:0]            tbl_addr,
   input  logic [31:0]           tbl_data,
   output logic [ADDR_W-1:0]     amm_addr,
   output logic [DATA_W-1:0]     amm_writedata,
   output logic                  amm_write,
   output logic                  amm_read,
   output logic [DATA_W/8-1:0]   amm_byteenable,
   output logic [6:0]            amm_burstcount,
   input  logic                  amm_ready,
   input  logic [DATA_W-1:0]     amm_readdata,
   input  logic                  amm_readdatavalid,
   output logic                  busy,
   output logic                  setup_done,
   output logic                  setup_fail,
   output logic [15:0]           err_count
);

   localparam int unsigned WPB       = DATA_W / 32;
   localparam int unsigned NUM_BEATS = (NUM_WORDS + WPB - 1) / WPB;
   localparam int unsigned BEAT_W    = 11;
   localparam int unsigned K_W       = 5;

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_CAL, S_FILL, S_WRITE, S_RD_FILL,
      S_RD_REQ, S_RD_WAIT, S_DONE, S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [15:0]         err_q, err_d;
   logic [31:0]         tmo_q, tmo_d;
   logic [7:0]          stray_q, stray_d;
   logic                done_q, done_d;
   logic                fail_q, fail_d;

   logic [31:0]         word_idx;
   logic [31:0]         word_in;
   logic                last_beat;
   logic                k_last;
   logic                idle_like;
   logic                valid_free;
   logic                resp;
   logic [15:0]         err_sat;

   always_comb begin
      word_idx   = 32'(beat_q) * 32'(WPB) + 32'(k_q);
      word_in    = (word_idx < 32'(NUM_WORDS)) ? tbl_data : '0;
      last_beat  = (beat_q == BEAT_W'(NUM_BEATS - 1));
      k_last     = (k_q == K_W'(WPB - 1));
      idle_like  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
      // Responses owed to timed-out reads are swallowed so they are never
      // mistaken for the reply to a later beat.
      valid_free = amm_readdatavalid && (stray_q == '0);
      err_sat    = (err_q == '1) ? err_q : err_q + 16'd1;
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      k_d     = k_q;
      data_d  = data_q;
      err_d   = err_q;
      tmo_d   = tmo_q;
      stray_d = stray_q;
      done_d  = done_q;
      fail_d  = fail_q;
      resp    = 1'b0;

      if (amm_readdatavalid && (stray_q != '0)) begin
         stray_d = stray_q - 8'd1;
      end

      unique case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               done_d  = 1'b0;
               fail_d  = 1'b0;
               err_d   = '0;
               beat_d  = '0;
               k_d     = '0;
               state_d = cal_success ? S_FILL : S_WAIT_CAL;
            end
         end
         S_WAIT_CAL: begin
            if (cal_success) state_d = S_FILL;
         end
         S_FILL, S_RD_FILL: begin
            data_d[32*k_q +: 32] = word_in;
            if (k_last) begin
               k_d     = '0;
               state_d = (state_q == S_FILL) ? S_WRITE : S_RD_REQ;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         S_WRITE: begin
            if (amm_ready) begin
               if (!last_beat) begin
                  beat_d  = beat_q + BEAT_W'(1);
                  state_d = S_FILL;
               end else if (VERIFY != 0) begin
                  beat_d  = '0;
                  state_d = S_RD_FILL;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_RD_REQ: begin
            if (amm_ready) begin
               tmo_d   = '0;
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (valid_free) begin
               resp = 1'b1;
               if (amm_readdata != data_q) err_d = err_sat;
            end else if (tmo_q == 32'(RD_TIMEOUT - 1)) begin
               resp  = 1'b1;
               err_d = err_sat;
               if (stray_d != '1) stray_d = stray_d + 8'd1;
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
            if (resp) begin
               if (last_beat) begin
                  if (err_d == '0) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     fail_d  = 1'b1;
                     state_d = S_FAIL;
                  end
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
                  state_d = S_RD_FILL;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge avalon_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         k_q     <= '0;
         data_q  <= '0;
         err_q   <= '0;
         tmo_q   <= '0;
         stray_q <= '0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         k_q     <= k_d;
         data_q  <= data_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         stray_q <= stray_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
      end
   end

   always_comb begin
      if ((state_q == S_FILL) || (state_q == S_RD_FILL)) begin
         tbl_addr = (word_idx >= 32'(NUM_WORDS)) ? 10'(NUM_WORDS - 1) : word_idx[9:0];
      end else begin
         tbl_addr = '0;
      end
      amm_write = (state_q == S_WRITE);
      amm_read  = (state_q == S_RD_REQ);
      amm_addr  = (amm_write || amm_read) ? (ADDR_W'(BASE_ADDR) + ADDR_W'(beat_q)) : '0;
   end

   assign amm_writedata  = data_q;
   assign amm_byteenable = '1;
   assign amm_burstcount = 7'd1;
   assign busy           = !idle_like;
   assign setup_done     = done_q;
   assign setup_fail     = fail_q;
   assign err_count      = err_q;

endmodule

// File: tb/tb_ddr_preload_engine.sv
// tb_ddr_preload_engine
//    Two engines share clock and reset: u_dut0 (defaults, write only) and
//    u_dut1 (read-back enabled, short read timeout) backed by a memory model.
//    Expected write/read commands are queued at each start and popped as the
//    engines issue accepted commands.
module tb_ddr_preload_engine;

   localparam int DW = 256;
   localparam int AW = 25;

   typedef struct {
      logic          rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic start0 = 1'b0, cal0 = 1'b1, rdy0 = 1'b1;
   logic [9:0] ta0;
   logic [31:0] td0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wd0;
   logic wr0, rd0, busy0, done0, fail0;
   logic [DW/8-1:0] be0;
   logic [6:0] bc0;
   logic [15:0] err0;

   logic start1 = 1'b0, rdy1 = 1'b1;
   logic [9:0] ta1;
   logic [31:0] td1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wd1;
   logic [DW-1:0] rdd1 = '0;
   logic rdv1 = 1'b0;
   logic wr1, rd1, busy1, done1, fail1;
   logic [DW/8-1:0] be1;
   logic [6:0] bc1;
   logic [15:0] err1;

   txn_t q0[$];
   txn_t q1[$];
   logic [DW-1:0] mem [int];
   int corrupt_addr = -1;
   int drop_addr = -1;
   int wr0_cnt = 0, wr1_cnt = 0, rd1_cnt = 0, both0 = 0, both1 = 0;
   int n_cmp = 0, n_mis = 0;

   function automatic logic [31:0] tbl_word(input logic [9:0] a);
      return 32'h5A00_0000 ^ {a, 12'h3C1, a};
   endfunction

   function automatic logic [DW-1:0] exp_beat(input int b);
      logic [DW-1:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) begin
         int idx;
         idx = b * 8 + k;
         if (idx < 28) v[32*k +: 32] = tbl_word(idx[9:0]);
      end
      return v;
   endfunction

   assign td0 = tbl_word(ta0);
   assign td1 = tbl_word(ta1);

   ddr_preload_engine u_dut0 (
      .avalon_clk(clk), .reset(rst), .start(start0), .cal_success(cal0),
      .tbl_addr(ta0), .tbl_data(td0), .amm_addr(addr0), .amm_writedata(wd0),
      .amm_write(wr0), .amm_read(rd0), .amm_byteenable(be0), .amm_burstcount(bc0),
      .amm_ready(rdy0), .amm_readdata('0), .amm_readdatavalid(1'b0),
      .busy(busy0), .setup_done(done0), .setup_fail(fail0), .err_count(err0)
   );

   ddr_preload_engine #(.VERIFY(1), .RD_TIMEOUT(8)) u_dut1 (
      .avalon_clk(clk), .reset(rst), .start(start1), .cal_success(1'b1),
      .tbl_addr(ta1), .tbl_data(td1), .amm_addr(addr1), .amm_writedata(wd1),
      .amm_write(wr1), .amm_read(rd1), .amm_byteenable(be1), .amm_burstcount(bc1),
      .amm_ready(rdy1), .amm_readdata(rdd1), .amm_readdatavalid(rdv1),
      .busy(busy1), .setup_done(done1), .setup_fail(fail1), .err_count(err1)
   );

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Command monitors: accepted at the next edge when request and ready are high.
   always @(negedge clk) begin
      txn_t t;
      if (wr0 && rd0) both0++;
      if (done0 && fail0) both0++;
      if (wr0 && rdy0) begin
         wr0_cnt++;
         check_eq("wr0_sb_nonempty", DW'(q0.size() != 0), DW'(1));
         if (q0.size() != 0) begin
            t = q0.pop_front();
            check_eq("wr0_addr", DW'(addr0), DW'(t.addr));
            check_eq("wr0_data", wd0, t.data);
            check_eq("wr0_be", DW'(be0), DW'({32{1'b1}}));
            check_eq("wr0_bc", DW'(bc0), DW'(1));
         end
      end
   end

   always @(negedge clk) begin
      txn_t t;
      if (wr1 && rd1) both1++;
      if (done1 && fail1) both1++;
      if ((wr1 || rd1) && rdy1) begin
         if (wr1) begin
            wr1_cnt++;
            mem[int'(addr1)] = wd1;
         end else begin
            rd1_cnt++;
         end
         check_eq("c1_sb_nonempty", DW'(q1.size() != 0), DW'(1));
         if (q1.size() != 0) begin
            t = q1.pop_front();
            check_eq("c1_kind", DW'(rd1), DW'(t.rd));
            check_eq("c1_addr", DW'(addr1), DW'(t.addr));
            if (!t.rd) check_eq("c1_data", wd1, t.data);
         end
      end
   end

   // Read responder: echoes memory one cycle after acceptance; a dropped beat
   // gets a late garbage reply that lands after the engine has timed out.
   always begin
      logic [AW-1:0] a;
      int d;
      @(negedge clk);
      if (rd1 && rdy1) begin
         a = addr1;
         d = (int'(a) == drop_addr) ? 12 : 1;
         repeat (d) @(posedge clk);
         #1;
         rdv1 = 1'b1;
         if (int'(a) == drop_addr) rdd1 = '1;
         else rdd1 = mem[int'(a)] ^ ((int'(a) == corrupt_addr) ? DW'(1) : DW'(0));
         @(posedge clk);
         #1;
         rdv1 = 1'b0;
      end
   end

   task automatic push0();
      for (int b = 0; b < 4; b++) q0.push_back('{1'b0, AW'(b), exp_beat(b)});
   endtask

   task automatic push1();
      for (int b = 0; b < 4; b++) q1.push_back('{1'b0, AW'(b), exp_beat(b)});
      for (int b = 0; b < 4; b++) q1.push_back('{1'b1, AW'(b), exp_beat(b)});
   endtask

   task automatic pulse0();
      @(posedge clk); #1 start0 = 1'b1;
      @(posedge clk); #1 start0 = 1'b0;
   endtask

   task automatic pulse1();
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
   endtask

   task automatic wait_end0(output int n);
      n = 0;
      while (!(done0 || fail0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("end0_timeout", DW'(n < 500), DW'(1));
   endtask

   task automatic wait_end1(output int n);
      n = 0;
      while (!(done1 || fail1) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("end1_timeout", DW'(n < 1000), DW'(1));
   endtask

   task automatic check_reset0(input string tag);
      check_eq({tag, "_wr"}, DW'(wr0), DW'(0));
      check_eq({tag, "_busy"}, DW'(busy0), DW'(0));
      check_eq({tag, "_done"}, DW'(done0), DW'(0));
      check_eq({tag, "_fail"}, DW'(fail0), DW'(0));
      check_eq({tag, "_err"}, DW'(err0), DW'(0));
      check_eq({tag, "_addr"}, DW'(addr0), DW'(0));
      check_eq({tag, "_wdata"}, wd0, DW'(0));
      check_eq({tag, "_taddr"}, DW'(ta0), DW'(0));
   endtask

   initial begin
      int n, base, bad_wr, bad_busy;
      repeat (3) @(posedge clk);
      #1;
      check_reset0("rst");
      check_eq("rst_rd", DW'(rd1), DW'(0));
      rst = 1'b0;

      // Plain preload, latency and final state
      push0();
      base = wr0_cnt;
      pulse0();
      wait_end0(n);
      check_eq("lat_done", DW'(n), DW'(36));
      check_eq("t1_done", DW'(done0), DW'(1));
      check_eq("t1_fail", DW'(fail0), DW'(0));
      check_eq("t1_busy", DW'(busy0), DW'(0));
      check_eq("t1_wr_cnt", DW'(wr0_cnt - base), DW'(4));
      check_eq("t1_sb_empty", DW'(q0.size()), DW'(0));

      // Calibration held off for 20 cycles
      cal0 = 1'b0;
      push0();
      base = wr0_cnt;
      pulse0();
      bad_wr = 0;
      bad_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (wr0) bad_wr++;
         if (!busy0) bad_busy++;
      end
      check_eq("cal_no_write", DW'(bad_wr), DW'(0));
      check_eq("cal_busy", DW'(bad_busy), DW'(0));
      cal0 = 1'b1;
      n = 0;
      while (!wr0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("cal_first_wr", DW'(n), DW'(9));
      wait_end0(n);
      check_eq("t2_done", DW'(done0), DW'(1));
      check_eq("t2_wr_cnt", DW'(wr0_cnt - base), DW'(4));

      // Backpressure on beat 1
      push0();
      base = wr0_cnt;
      pulse0();
      n = 0;
      while (!(wr0 && addr0 == AW'(1)) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("bp_found", DW'(n < 100), DW'(1));
      rdy0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_eq("bp_wr", DW'(wr0), DW'(1));
         check_eq("bp_addr", DW'(addr0), DW'(1));
         check_eq("bp_data", wd0, exp_beat(1));
         if (i < 5) begin
            @(posedge clk); #1;
         end
      end
      rdy0 = 1'b1;
      wait_end0(n);
      check_eq("t3_done", DW'(done0), DW'(1));
      check_eq("t3_wr_cnt", DW'(wr0_cnt - base), DW'(4));
      check_eq("t3_sb_empty", DW'(q0.size()), DW'(0));

      // Reset during beat 2, extra starts while busy
      push0();
      pulse0();
      pulse0();
      pulse0();
      n = 0;
      while (!(wr0 && addr0 == AW'(2)) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("mid_found", DW'(n < 100), DW'(1));
      rdy0 = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset0("mid_rst");
      rst = 1'b0;
      rdy0 = 1'b1;
      check_eq("mid_left", DW'(q0.size()), DW'(2));
      q0.delete();
      push0();
      base = wr0_cnt;
      pulse0();
      wait_end0(n);
      check_eq("t4_lat", DW'(n), DW'(36));
      check_eq("t4_done", DW'(done0), DW'(1));
      check_eq("t4_wr_cnt", DW'(wr0_cnt - base), DW'(4));

      // Read-back, echo memory
      push1();
      base = rd1_cnt;
      pulse1();
      wait_end1(n);
      check_eq("echo_done", DW'(done1), DW'(1));
      check_eq("echo_fail", DW'(fail1), DW'(0));
      check_eq("echo_err", DW'(err1), DW'(0));
      check_eq("echo_rd_cnt", DW'(rd1_cnt - base), DW'(4));

      // Read-back with beat 2 corrupted
      corrupt_addr = 2;
      push1();
      pulse1();
      wait_end1(n);
      check_eq("corr_fail", DW'(fail1), DW'(1));
      check_eq("corr_done", DW'(done1), DW'(0));
      check_eq("corr_err", DW'(err1), DW'(1));
      corrupt_addr = -1;

      // Read timeout on beat 0, late stray reply
      drop_addr = 0;
      push1();
      base = rd1_cnt;
      pulse1();
      check_eq("tmo_err_clr", DW'(err1), DW'(0));
      n = 0;
      while (!rd1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("tmo_rd_found", DW'(n < 200), DW'(1));
      @(posedge clk); #1;
      n = 0;
      while (err1 == 16'd0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("tmo_cycles", DW'(n), DW'(8));
      wait_end1(n);
      check_eq("tmo_fail", DW'(fail1), DW'(1));
      check_eq("tmo_done", DW'(done1), DW'(0));
      check_eq("tmo_err", DW'(err1), DW'(1));
      check_eq("tmo_rd_cnt", DW'(rd1_cnt - base), DW'(4));
      check_eq("tmo_sb_empty", DW'(q1.size()), DW'(0));
      drop_addr = -1;

      check_eq("excl0", DW'(both0), DW'(0));
      check_eq("excl1", DW'(both1), DW'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
